// File: rtl/rate_counter.sv
// Rate-selectable up/down counter: steps once per rising edge of a chosen divided_clocks bit,
// with blanking after a rate change, synchronous load, and registered tick/wrap pulses.
module rate_counter #(
  parameter int WIDTH      = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      divided_clocks,
  input  logic [4:0]       rate_sel,
  input  logic             run,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap
);

  localparam int SW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC);

  typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_e;

  state_e            state_q,     state_d;
  logic              samp_q,      samp_d;
  logic              samp_prev_q, samp_prev_d;
  logic [4:0]        sel_q,       sel_d;
  logic [SW-1:0]     settle_q,    settle_d;
  logic [WIDTH-1:0]  count_q,     count_d;
  logic              tick_q,      tick_d;
  logic              wrap_q,      wrap_d;

  logic rise;
  logic sel_change;
  logic step;

  assign rise       = samp_q & ~samp_prev_q;
  assign sel_change = (rate_sel != sel_q);

  // NOTE: every signal gets a default before the branches so no path leaves it unassigned (no latches).
  always_comb begin
    samp_d      = divided_clocks[rate_sel];
    samp_prev_d = samp_q;
    sel_d       = rate_sel;
    state_d     = state_q;
    settle_d    = settle_q;
    count_d     = count_q;
    tick_d      = 1'b0;
    wrap_d      = 1'b0;
    step        = 1'b0;

    // A rate change blanks stepping until the new sample pipeline holds only new-rate data.
    if (sel_change) begin
      state_d  = SETTLE;
      settle_d = SETTLE_LOAD;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (run) state_d = RUN;
        end
        RUN: begin
          if (!run)      state_d = IDLE;
          else if (rise) step    = 1'b1;
        end
        SETTLE: begin
          if (settle_q <= SW'(1)) begin
            state_d  = run ? RUN : IDLE;
            settle_d = '0;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      count_d = load_val;
    end else if (step) begin
      tick_d = 1'b1;
      if (up) begin
        count_d = count_q + 1'b1;
        wrap_d  = &count_q;
      end else begin
        count_d = count_q - 1'b1;
        wrap_d  = ~|count_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      samp_q      <= 1'b0;
      samp_prev_q <= 1'b0;
      sel_q       <= '0;
      settle_q    <= '0;
      count_q     <= '0;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      samp_prev_q <= samp_prev_d;
      sel_q       <= sel_d;
      settle_q    <= settle_d;
      count_q     <= count_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: doc/rate_counter.md
RATE_COUNTER -- requirements
Module: rate_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 3: bit width of count and load_val.
REQ-002 SHALL have parameter SETTLE_CYC, default 2: tick-blanking cycles after a rate_sel change.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port divided_clocks, input, 32 bits: free-running divider bus, synchronous to clk.
REQ-006 SHALL have port rate_sel, input, 5 bits: index of the divided_clocks bit used as the count rate.
REQ-007 SHALL have port run, input, 1 bit: high means count on ticks; low means freeze.
REQ-008 SHALL have port up, input, 1 bit: count direction; 1 is increment, 0 is decrement.
REQ-009 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-010 SHALL have port load_val, input, WIDTH bits: value written to count on load.
REQ-011 SHALL have port count, output, WIDTH bits: registered counter value.
REQ-012 SHALL have port tick, output, 1 bit: registered one-cycle pulse marking each count step.
REQ-013 SHALL have port wrap, output, 1 bit: registered one-cycle pulse marking rollover.

Function
REQ-014 SHALL register samp <= divided_clocks[rate_sel] and samp_d <= samp every cycle; edge = samp & ~samp_d.
REQ-015 SHALL implement FSM states IDLE, RUN and SETTLE, held in a registered state variable.
REQ-016 IDLE: SHALL go to RUN when run=1; SHALL stay in IDLE otherwise; count SHALL be frozen.
REQ-017 RUN: on edge=1, SHALL step count by 1 in the direction of up and assert tick the same cycle.
REQ-018 RUN: SHALL go to IDLE on the first cycle run=0, with no step on that cycle even if edge=1.
REQ-019 rate_sel differing from its registered previous value, in any state, SHALL force SETTLE for SETTLE_CYC cycles.
REQ-020 SETTLE: SHALL suppress steps and tick; at expiry SHALL go to RUN if run=1, else to IDLE.
REQ-021 SETTLE: a further rate_sel change SHALL restart the blanking count.
REQ-022 Step latency: selected bit first sampled 1 at edge N SHALL update count and tick at edge N+1.
REQ-023 count arithmetic SHALL be modulo 2^WIDTH.
REQ-024 Up-step from 2^WIDTH-1 to 0 SHALL assert wrap for that cycle.
REQ-025 Down-step from 0 to 2^WIDTH-1 SHALL assert wrap for that cycle.
REQ-026 load=1, in any state, SHALL set count <= load_val next edge, with tick=0 and wrap=0.
REQ-027 load SHALL take priority over a simultaneous step, and SHALL NOT change FSM state.
REQ-028 rate_sel=0 SHALL yield, in RUN, one step every 2 clk cycles.
REQ-029 tick and wrap SHALL never be high for more than one consecutive cycle per edge.
REQ-030 wrap SHALL only be high together with tick.
REQ-031 up SHALL be sampled on the step cycle only; changes between steps SHALL have no effect.

Reset
REQ-032 reset=1 SHALL immediately, without a clk edge, force count=0, tick=0, wrap=0, state=IDLE.
REQ-033 reset=1 SHALL immediately force samp=0, samp_d=0, settle counter=0, and registered rate_sel=0.
REQ-034 reset mid-count or mid-SETTLE SHALL discard progress; after release the block SHALL behave as from power-up.
REQ-035 No output SHALL change on the first clk edge after reset release unless load=1.

Verification
REQ-036 rate_sel=0, run=1, up=1, from reset -> count 0,1,..,7,0 every 2 cycles; wrap exactly on the 7->0 step.
REQ-037 up=0, count=0, one step -> count=7, tick=1, wrap=1 for one cycle.
REQ-038 load=1, load_val=5 on the same cycle as an edge in RUN -> count=5, tick=0, wrap=0.
REQ-039 rate_sel 2->3 while in RUN -> no tick for 2 cycles (SETTLE), then steps every 16 cycles.
REQ-040 run dropped on an edge cycle -> no step; state=IDLE; count is held while run=0.
REQ-041 reset asserted asynchronously with count=6, between clk edges -> count=0 and tick=0 before the next edge.
